// File: rtl/insn_fetch_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | insn_fetch_queue: imem prefetch FIFO feeding decode, with redirect flushing.  |
// | Optional FETCH_BYPASS_EN lets an empty-queue response reach decode the same   |
// | cycle it arrives.                                                             |
// | Rev 1.0                                                                       |
// +-----------------------------------------------------------------------------+
module insn_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] NOP_WORD = 16'h0201
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_ir,
  output logic [15:0] out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] C_DEPTH_OCC = (CW + 1)'(DEPTH);

  logic [15:0]   fpc_q, fpc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          inflight_q, inflight_d;
  logic          epoch_q, epoch_d;
  logic [15:0]   req_pc_q, req_pc_d;
  logic          req_epoch_q, req_epoch_d;
  logic [15:0]   fifo_ir_q [DEPTH];
  logic [15:0]   fifo_ir_d [DEPTH];
  logic [15:0]   fifo_pc_q [DEPTH];
  logic [15:0]   fifo_pc_d [DEPTH];

  logic [CW:0]   occupancy;
  logic          issue;
  logic          resp_ok;
  logic          bypass;
  logic          fire;
  logic          push;
  logic          fifo_pop;

  // Credits count the in-flight word so a full FIFO can never be overrun.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue     = !reset && !redirect && !halt && (occupancy < C_DEPTH_OCC);
    resp_ok   = inflight_q && (req_epoch_q == epoch_q) && !redirect;
`ifdef FETCH_BYPASS_EN
    bypass    = resp_ok && (count_q == '0);
`else
    bypass    = 1'b0;
`endif
    out_valid = ((count_q != '0) || bypass) && !redirect;
    out_ir    = NOP_WORD;
    out_pc    = 16'h0000;
    if (bypass) begin
      out_ir = imem_data;
      out_pc = req_pc_q;
    end else if (count_q != '0) begin
      out_ir = fifo_ir_q[rd_ptr_q];
      out_pc = fifo_pc_q[rd_ptr_q];
    end
    fire      = out_valid && out_ready;
    fifo_pop  = fire && (count_q != '0);
    push      = resp_ok && !(bypass && fire);
    imem_rd   = issue;
    imem_addr = fpc_q;
  end

  always_comb begin
    fpc_d       = fpc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    inflight_d  = issue;
    epoch_d     = epoch_q;
    req_pc_d    = req_pc_q;
    req_epoch_d = req_epoch_q;
    fifo_ir_d   = fifo_ir_q;
    fifo_pc_d   = fifo_pc_q;

    if (issue) begin
      fpc_d       = fpc_q + 16'd1;
      req_pc_d    = fpc_q;
      req_epoch_d = epoch_q;
    end

    // The epoch toggle marks anything requested before the redirect as stale.
    if (redirect) begin
      fpc_d    = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      epoch_d  = !epoch_q;
    end else begin
      if (push) begin
        fifo_ir_d[wr_ptr_q] = imem_data;
        fifo_pc_d[wr_ptr_q] = req_pc_q;
        wr_ptr_d            = wr_ptr_q + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, fifo_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q       <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      epoch_q     <= 1'b0;
      req_pc_q    <= '0;
      req_epoch_q <= 1'b0;
      fifo_ir_q   <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
    end else begin
      fpc_q       <= fpc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      inflight_q  <= inflight_d;
      epoch_q     <= epoch_d;
      req_pc_q    <= req_pc_d;
      req_epoch_q <= req_epoch_d;
      fifo_ir_q   <= fifo_ir_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_insn_fetch_queue.sv
`default_nettype none
// Bench for insn_fetch_queue: directed scenarios plus random traffic, scored
// against an ordered model of "every request since the last flush, in order".
module tb_insn_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] NOP_WORD = 16'h0201;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_ir;
  logic [15:0] out_pc;

  always #5 clk = ~clk;

  insn_fetch_queue #(.DEPTH(DEPTH), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .reset(reset),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc)
  );

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    int          issued;
  } item_t;

  item_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [15:0] exp_fpc = 16'h0000;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (a < 16'd6) return 16'hB010 + a;
    return (a * 16'h9E37) ^ 16'h5A5A ^ {a[7:0], a[15:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Synchronous memory: the word for a request appears the cycle after it.
  logic        mem_pend;
  logic [15:0] mem_addr;
  always begin
    @(negedge clk);
    mem_pend = imem_rd;
    mem_addr = imem_addr;
    @(posedge clk);
    #1;
    imem_data = mem_pend ? word_at(mem_addr) : 16'($urandom);
  end

  // Monitor / scoreboard
  int  occ;
  bit  landed;
  bit  exp_issue;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_imem_rd", 32'(imem_rd), 32'(0));
      check("rst_out_ir", 32'(out_ir), 32'(NOP_WORD));
      check("rst_imem_addr", 32'(imem_addr), 32'(0));
      exp_q.delete();
      exp_fpc = 16'h0000;
    end else begin
      occ       = exp_q.size();
      landed    = (occ != 0) && (exp_q[0].issued + LAT <= cyc) && !redirect;
      exp_issue = !redirect && !halt && (occ < DEPTH);
      check("issue_gate", 32'(imem_rd), 32'(exp_issue));
      check("out_valid", 32'(out_valid), 32'(landed));
      if (out_valid && landed) begin
        check("out_pc", 32'(out_pc), 32'(exp_q[0].pc));
        check("out_ir", 32'(out_ir), 32'(exp_q[0].ir));
      end
      if (!redirect && !landed) begin
        check("idle_ir_nop", {out_ir, out_pc}, {NOP_WORD, 16'h0000});
      end
      if (redirect) begin
        exp_q.delete();
        exp_fpc = redirect_pc;
      end else begin
        if (out_valid && out_ready && occ != 0) void'(exp_q.pop_front());
        if (imem_rd) begin
          check("imem_addr", 32'(imem_addr), 32'(exp_fpc));
          exp_q.push_back('{ir: word_at(exp_fpc), pc: exp_fpc, issued: cyc});
          exp_fpc = exp_fpc + 16'd1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect = 1'b1;
    redirect_pc = pc;
    tick(1);
    redirect = 1'b0;
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    // Streaming from reset
    tick(12);
    // Backpressure fills the queue, then drains
    out_ready = 1'b0;
    tick(10);
    out_ready = 1'b1;
    tick(10);
    // Redirect with three queued and one in flight
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    out_ready = 1'b0;
    tick(4);
    do_redirect(16'h0040);
    out_ready = 1'b1;
    tick(8);
    // Back-to-back redirects
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    tick(1);
    redirect_pc = 16'h0020;
    tick(1);
    redirect = 1'b0;
    tick(6);
    // Address wrap
    do_redirect(16'hFFFE);
    tick(8);
    // Halt with two queued, then reset mid-stream
    do_redirect(16'h0100);
    out_ready = 1'b0;
    tick(2);
    halt = 1'b1;
    tick(3);
    out_ready = 1'b1;
    tick(6);
    halt = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(6);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(9) < 7);
      halt      = ($urandom_range(9) == 0);
      redirect  = ($urandom_range(19) == 0);
      if ($urandom_range(3) == 0) redirect_pc = 16'hFFFC + 16'($urandom_range(3));
      else                        redirect_pc = 16'($urandom);
      reset     = ($urandom_range(199) == 0);
      tick(1);
    end
    reset = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    out_ready = 1'b1;
    tick(10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
